// File: rtl/de0_cv_led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : de0_cv_led_pkg                                               |
// | Description : Shared constants for the DE0-CV LED dimmer: register word    |
// |               addresses, CTRL bit positions and the PWM counter maximum.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package de0_cv_led_pkg;

  // Avalon-MM register word addresses
  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_BRIGHT   = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_FADE_DIV = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;

  // CTRL bit positions and reset value (enable on, fading off)
  localparam int         CTRL_ENABLE_BIT  = 0;
  localparam int         CTRL_FADE_EN_BIT = 1;
  localparam logic [1:0] CTRL_RESET       = 2'b01;

  // PWM counter runs 0..PWM_MAX, i.e. a 255-tick period so level 255 is solid on
  localparam logic [7:0] PWM_MAX = 8'd254;

endpackage
`default_nettype wire

// File: rtl/de0_cv_led_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : de0_cv_led_channel                                           |
// | Description : One LED channel: brightness level register with optional    |
// |               linear fade toward the target, and the registered PWM bit.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   target_i      level this channel should settle at
//   fade_en_i     1: step one count per fade_tick_i; 0: follow target_i directly
//   fade_tick_i   fade step strobe
//   pwm_cnt_i     shared PWM counter
//   enable_i      global output enable
//   level_o       current level register
//   busy_o        level has not yet reached target
//   led_o         registered PWM drive bit
module de0_cv_led_channel #(
  parameter int LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LEVEL_W-1:0] target_i,
  input  logic               fade_en_i,
  input  logic               fade_tick_i,
  input  logic [LEVEL_W-1:0] pwm_cnt_i,
  input  logic               enable_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               busy_o,
  output logic               led_o
);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               led_q, led_d;

  always_comb begin
    level_d = level_q;
    if (!fade_en_i) begin
      // Without fading (or when fading is switched off mid-ramp) snap to target.
      level_d = target_i;
    end else if (fade_tick_i) begin
      // One step toward target; the explicit compares prevent overshoot and wrap.
      if (level_q < target_i) begin
        level_d = level_q + LEVEL_W'(1);
      end else if (level_q > target_i) begin
        level_d = level_q - LEVEL_W'(1);
      end
    end
    led_d = enable_i & (level_q > pwm_cnt_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign level_o = level_q;
  assign busy_o  = (level_q != target_i);
  assign led_o   = led_q;

endmodule
`default_nettype wire

// File: rtl/de0_cv_led_dimmer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : de0_cv_led_dimmer                                            |
// | Description : PWM LED dimmer between the LED PIO and the LEDR pins, with   |
// |               per-channel linear fade and an Avalon-MM control slave.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        register word address (0 CTRL, 1 BRIGHT, 2 PRESCALE,
//                  3 FADE_DIV, 4 STATUS)
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       combinational read data, zero wait states
//   pattern_in     LED pattern from the PIO
//   led_out        registered PWM drive to the LEDs
module de0_cv_led_dimmer
  import de0_cv_led_pkg::*;
#(
  parameter int          NUM_LEDS         = 10,
  parameter int          LEVEL_W          = 8,
  parameter logic [15:0] PRESCALE_DEFAULT = 16'd195,
  parameter logic [7:0]  FADE_DIV_DEFAULT = 8'd3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [NUM_LEDS-1:0] pattern_in,
  output logic [NUM_LEDS-1:0] led_out
);

  logic [1:0]          ctrl_q, ctrl_d;
  logic [LEVEL_W-1:0]  bright_q, bright_d;
  logic [15:0]         prescale_q, prescale_d;
  logic [7:0]          fade_div_q, fade_div_d;
  logic [15:0]         pre_cnt_q, pre_cnt_d;
  logic [LEVEL_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          fd_cnt_q, fd_cnt_d;
  logic [NUM_LEDS-1:0] pat_q;

  logic                wr, prescale_wr;
  logic                pwm_tick, period_end, fade_tick;
  logic [NUM_LEDS-1:0] busy;
  logic [NUM_LEDS-1:0] led_bits;
  logic [LEVEL_W-1:0]  chan_level [NUM_LEDS];

  always_comb begin
    wr          = chipselect & ~write_n;
    prescale_wr = wr && (address == ADDR_PRESCALE);
    pwm_tick    = (pre_cnt_q == prescale_q);
    period_end  = pwm_tick && (pwm_cnt_q == LEVEL_W'(PWM_MAX));
    fade_tick   = period_end && (fd_cnt_q == fade_div_q);

    ctrl_d     = ctrl_q;
    bright_d   = bright_q;
    prescale_d = prescale_q;
    fade_div_d = fade_div_q;
    if (wr) begin
      case (address)
        ADDR_CTRL:     ctrl_d     = writedata[1:0];
        ADDR_BRIGHT:   bright_d   = writedata[LEVEL_W-1:0];
        ADDR_PRESCALE: prescale_d = writedata[15:0];
        ADDR_FADE_DIV: fade_div_d = writedata[7:0];
        default:       ;
      endcase
    end

    // Ticks are decoded from the current (pre-write) register values.
    pre_cnt_d = pre_cnt_q + 16'd1;
    pwm_cnt_d = pwm_cnt_q;
    if (prescale_wr) begin
      pre_cnt_d = '0;
      pwm_cnt_d = '0;
    end else if (pwm_tick) begin
      pre_cnt_d = '0;
      pwm_cnt_d = (pwm_cnt_q == LEVEL_W'(PWM_MAX)) ? '0 : pwm_cnt_q + LEVEL_W'(1);
    end

    // Restart on >= so a FADE_DIV reduced below the running count recovers at
    // the next period end instead of counting through 255.
    fd_cnt_d = fd_cnt_q;
    if (period_end) begin
      fd_cnt_d = (fd_cnt_q >= fade_div_q) ? 8'd0 : fd_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= CTRL_RESET;
      bright_q   <= '1;
      prescale_q <= PRESCALE_DEFAULT;
      fade_div_q <= FADE_DIV_DEFAULT;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      fd_cnt_q   <= '0;
      pat_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      bright_q   <= bright_d;
      prescale_q <= prescale_d;
      fade_div_q <= fade_div_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fd_cnt_q   <= fd_cnt_d;
      pat_q      <= pattern_in;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    de0_cv_led_channel #(
      .LEVEL_W (LEVEL_W)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .target_i    (pat_q[i] ? bright_q : '0),
      .fade_en_i   (ctrl_q[CTRL_FADE_EN_BIT]),
      .fade_tick_i (fade_tick),
      .pwm_cnt_i   (pwm_cnt_q),
      .enable_i    (ctrl_q[CTRL_ENABLE_BIT]),
      .level_o     (chan_level[i]),
      .busy_o      (busy[i]),
      .led_o       (led_bits[i])
    );
  end

  assign led_out = led_bits;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:     readdata[1:0]          = ctrl_q;
      ADDR_BRIGHT:   readdata[LEVEL_W-1:0]  = bright_q;
      ADDR_PRESCALE: readdata[15:0]         = prescale_q;
      ADDR_FADE_DIV: readdata[7:0]          = fade_div_q;
      ADDR_STATUS:   readdata[NUM_LEDS-1:0] = busy;
      default:       readdata               = '0;
    endcase
  end

  // Upper write bits have no register behind them; channel level taps are
  // kept on the channel interface for debug visibility only.
  logic unused_sink;
  always_comb begin
    unused_sink = ^writedata[31:16];
    for (int i = 0; i < NUM_LEDS; i++) begin
      unused_sink = unused_sink ^ (^chan_level[i]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_de0_cv_led_dimmer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_de0_cv_led_dimmer                                         |
// | Description : Self-checking bench for de0_cv_led_dimmer: directed cases    |
// |               with literal expectations plus randomized traffic compared   |
// |               every cycle against a behavioural model.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_de0_cv_led_dimmer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  pattern_in;
  logic [9:0]  led_out;

  always #5 clk = ~clk;

  de0_cv_led_dimmer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pattern_in (pattern_in),
    .led_out    (led_out)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // PWM position is derived arithmetically from the cycles elapsed since the
  // counters were last cleared (reset or PRESCALE write).
  logic [1:0]  m_ctrl   = 2'b01;
  logic [7:0]  m_bright = 8'hFF;
  logic [15:0] m_pres   = 16'd195;
  logic [7:0]  m_fdiv   = 8'd3;
  int          m_n      = 0;
  int          m_fd     = 0;
  logic [9:0]  m_pat    = '0;
  logic [9:0]  m_led    = '0;
  int          m_lvl [10];

  int          t_per, t_pwm, t_tgt;
  bit          t_tick, t_pe, t_ft, t_wr;

  function automatic int m_target(input int i);
    return m_pat[i] ? int'(m_bright) : 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r = {30'd0, m_ctrl};
      3'd1: r = {24'd0, m_bright};
      3'd2: r = {16'd0, m_pres};
      3'd3: r = {24'd0, m_fdiv};
      3'd4: for (int i = 0; i < 10; i++) r[i] = (m_lvl[i] != m_target(i));
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ctrl = 2'b01; m_bright = 8'hFF; m_pres = 16'd195; m_fdiv = 8'd3;
      m_n = 0; m_fd = 0; m_pat = '0; m_led = '0;
      for (int i = 0; i < 10; i++) m_lvl[i] = 0;
    end else begin
      t_per  = int'(m_pres) + 1;
      t_pwm  = (m_n / t_per) % 255;
      t_tick = ((m_n % t_per) == int'(m_pres));
      t_pe   = t_tick && (t_pwm == 254);
      t_ft   = t_pe && (m_fd == int'(m_fdiv));
      for (int i = 0; i < 10; i++) begin
        m_led[i] = m_ctrl[0] && (m_lvl[i] > t_pwm);
        t_tgt = m_target(i);
        if (!m_ctrl[1]) m_lvl[i] = t_tgt;
        else if (t_ft && m_lvl[i] < t_tgt) m_lvl[i] = m_lvl[i] + 1;
        else if (t_ft && m_lvl[i] > t_tgt) m_lvl[i] = m_lvl[i] - 1;
      end
      if (t_pe) m_fd = (m_fd >= int'(m_fdiv)) ? 0 : m_fd + 1;
      t_wr = chipselect && !write_n;
      m_n  = (t_wr && address == 3'd2) ? 0 : m_n + 1;
      m_pat = pattern_in;
      if (t_wr) begin
        case (address)
          3'd0: m_ctrl   = writedata[1:0];
          3'd1: m_bright = writedata[7:0];
          3'd2: m_pres   = writedata[15:0];
          3'd3: m_fdiv   = writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("led_out_model", {22'd0, led_out}, {22'd0, m_led});
      check("readdata_model", readdata, m_read(address));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  logic [31:0] d;
  int          cnt, bad;
  logic [31:0] exp_rd [8];

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; pattern_in = 10'h001;
    step();
    chk_en = 1'b1;
    step(); step();
    check("reset_led", {22'd0, led_out}, 32'd0);
    rd(3'd0, d); check("reset_ctrl", d, 32'h1);
    rd(3'd1, d); check("reset_bright", d, 32'hFF);

    // Test 1: default brightness, one LED on, three-edge latency
    reset_n = 1'b1;
    step(); step();
    check("t1_led_edge2", {22'd0, led_out}, 32'd0);
    step();
    check("t1_led_edge3", {22'd0, led_out}, 32'h001);
    rd(3'd4, d); check("t1_status", d, 32'd0);
    repeat (20) step();
    check("t1_led_steady", {22'd0, led_out}, 32'h001);

    // Test 2: half brightness, fast PWM -> 128 of every 255 clocks high
    wr(3'd1, 32'h80);
    pattern_in = 10'h3FF;
    wr(3'd2, 32'h0);
    repeat (5) step();
    cnt = 0; bad = 0;
    for (int c = 0; c < 255; c++) begin
      if (led_out[0]) cnt++;
      if (led_out != 10'h000 && led_out != 10'h3FF) bad++;
      step();
    end
    check("t2_duty", cnt, 32'd128);
    check("t2_uniform", bad, 32'd0);

    // Test 3: fade 0 -> 4 at one step per PWM period
    wr(3'd0, 32'h1);
    wr(3'd3, 32'h0);
    wr(3'd1, 32'h4);
    pattern_in = 10'h000;
    repeat (5) step();
    wr(3'd0, 32'h3);
    repeat (300) step();
    pattern_in = 10'h001;
    wr(3'd2, 32'h0);
    repeat (1019) step();
    rd(3'd4, d); check("t3_busy_1019", d, 32'h1);
    step();
    rd(3'd4, d); check("t3_done_1020", d, 32'h0);

    // Ramp back down 4 -> 0
    pattern_in = 10'h000;
    wr(3'd2, 32'h0);
    repeat (1019) step();
    rd(3'd4, d); check("t3_down_busy", d, 32'h1);
    step();
    rd(3'd4, d); check("t3_down_done", d, 32'h0);

    // Test 4: retarget at level 2 -> ramps 2,1,0
    pattern_in = 10'h001;
    wr(3'd2, 32'h0);
    repeat (600) step();
    pattern_in = 10'h000;
    repeat (419) step();
    rd(3'd4, d); check("t4_busy_1019", d, 32'h1);
    step();
    rd(3'd4, d); check("t4_done_1020", d, 32'h0);

    // Test 5: enable gating
    wr(3'd0, 32'h1);
    wr(3'd1, 32'hFF);
    pattern_in = 10'h3FF;
    repeat (4) step();
    check("t5_all_on", {22'd0, led_out}, 32'h3FF);
    wr(3'd0, 32'h0);
    step();
    check("t5_disabled", {22'd0, led_out}, 32'h000);
    wr(3'd0, 32'h1);
    step();
    check("t5_reenabled", {22'd0, led_out}, 32'h3FF);

    // Test 6: undefined address writes/reads
    wr(3'd7, 32'hFFFF_FFFF);
    exp_rd = '{32'h1, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      check($sformatf("t6_read_%0d", a), d, exp_rd[a]);
      step();
    end

    // Randomized traffic, checked by the model every cycle
    wr(3'd2, {31'd0, 1'($urandom_range(0, 1))});
    wr(3'd0, 32'h3);
    for (int c = 0; c < 6000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      chipselect = 1'b0; write_n = 1'b1;
      address = 3'($urandom_range(0, 7));
      if (r < 4) begin
        chipselect = 1'b1; write_n = 1'b0;
        do address = 3'($urandom_range(0, 7)); while (address == 3'd2);
        writedata = $urandom;
        if (address == 3'd3) writedata[7:0] = 8'($urandom_range(0, 2));
        if (address == 3'd1) writedata[7:0] = 8'($urandom_range(0, 12));
      end else if (r < 8) begin
        chipselect = r[0]; write_n = ~r[0] ? 1'b0 : 1'b1;
        writedata = $urandom;
      end
      if ($urandom_range(0, 39) == 0) pattern_in = 10'($urandom);
      step();
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Reset asserted mid-ramp
    wr(3'd0, 32'h3);
    wr(3'd3, 32'h0);
    wr(3'd2, 32'h0);
    wr(3'd1, 32'hFF);
    pattern_in = 10'h3FF;
    repeat (400) step();
    address = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_led", {22'd0, led_out}, 32'd0);
    check("rst_mid_ctrl", readdata, 32'h1);
    step();
    rd(3'd1, d); check("rst_mid_bright", d, 32'hFF);
    rd(3'd2, d); check("rst_mid_prescale", d, 32'd195);
    rd(3'd3, d); check("rst_mid_fade_div", d, 32'd3);
    step();
    reset_n = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
